// File: rtl/mult_pipe_pkg.sv
// Shared helpers for the radix-2^K pipelined multiplier.
//   calc_ns : number of shift-add stages, ceil(b_w / k)
//   k_legal : 1 when k is a supported radix step (1, 2 or 4)
package mult_pipe_pkg;

    function automatic int calc_ns(input int b_w, input int k);
        return (b_w + k - 1) / k;
    endfunction

    function automatic bit k_legal(input int k);
        return (k == 1) || (k == 2) || (k == 4);
    endfunction

endpackage

// File: rtl/mult_pipe_rdx_if.sv
// Operand/result handshake bundle for mult_pipe_rdx.
//   in_valid/in_ready  : operand pair offer / accept
//   in_signed          : 1 = two's complement operands, 0 = unsigned
//   in_a, in_b, in_tag : multiplicand, multiplier, user tag
//   out_valid/out_ready: result offer / accept
//   out_p, out_tag     : product (A_W+B_W bits) and its tag
interface mult_pipe_rdx_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [A_W-1:0]     in_a;
    logic [B_W-1:0]     in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [A_W+B_W-1:0] out_p;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/mult_pipe_rdx_stage.sv
// One shift-add stage: retires K multiplier bits per cycle.
//   clk, rst         : clock, async active-high reset
//   i_en             : global advance enable (0 = stall, hold everything)
//   i_vld/o_vld      : slot valid
//   i_sgn/o_sgn      : result sign carried to the post-stage
//   i_tag/o_tag      : user tag
//   i_a/o_a          : multiplicand magnitude, shifted left by K per stage
//   i_b/o_b          : remaining multiplier bits, shifted right by K per stage
//   i_acc/o_acc      : running partial-product sum
module mult_pipe_rdx_stage #(
    parameter int P_W   = 16,
    parameter int BP_W  = 8,
    parameter int K     = 2,
    parameter int TAG_W = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic             i_sgn,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [P_W-1:0]   i_a,
    input  logic [BP_W-1:0]  i_b,
    input  logic [P_W-1:0]   i_acc,
    output logic             o_vld,
    output logic             o_sgn,
    output logic [TAG_W-1:0] o_tag,
    output logic [P_W-1:0]   o_a,
    output logic [BP_W-1:0]  o_b,
    output logic [P_W-1:0]   o_acc
);
    // Single K-bit digit multiply rather than a chain of K conditional adds.
    logic [P_W-1:0] w_pp;
    assign w_pp = i_a * P_W'(i_b[K-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_sgn <= 1'b0;
            o_tag <= '0;
            o_a   <= '0;
            o_b   <= '0;
            o_acc <= '0;
        end else if (i_en) begin
            o_vld <= i_vld;
            o_sgn <= i_sgn;
            o_tag <= i_tag;
            o_a   <= i_a << K;
            o_b   <= i_b >> K;
            o_acc <= i_acc + w_pp;
        end
    end
endmodule

// File: rtl/mult_pipe_rdx.sv
// Pipelined signed/unsigned multiplier, K multiplier bits per stage.
// Pipeline: pre-stage (magnitudes, sign) -> NS shift-add stages ->
// post-stage (conditional negate). Latency NS+2, one result per cycle,
// whole pipe stalls together when the output is held.
//   clk, rst : clock, async active-high reset
//   bus      : mult_pipe_rdx_if slave (operand and result handshakes)
module mult_pipe_rdx
    import mult_pipe_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int K     = 2,
    parameter int TAG_W = 4
)(
    input  logic           clk,
    input  logic           rst,
    mult_pipe_rdx_if.slave bus
);
    localparam int NS   = calc_ns(B_W, K);
    localparam int P_W  = A_W + B_W;
    localparam int BP_W = NS * K;   // multiplier padded with zeros to whole digits

    if (!k_legal(K)) begin : g_bad_k
        $error("mult_pipe_rdx: K must be 1, 2 or 4");
    end

    logic w_en;
    assign w_en         = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = w_en;

    // Magnitudes stay unsigned at full operand width, so -2^(W-1) maps to
    // 2^(W-1) without overflow.
    logic           w_a_neg, w_b_neg;
    logic [A_W-1:0] w_a_mag;
    logic [B_W-1:0] w_b_mag;
    assign w_a_neg = bus.in_signed & bus.in_a[A_W-1];
    assign w_b_neg = bus.in_signed & bus.in_b[B_W-1];
    assign w_a_mag = w_a_neg ? -bus.in_a : bus.in_a;
    assign w_b_mag = w_b_neg ? -bus.in_b : bus.in_b;

    logic             r_pre_vld, r_pre_sgn;
    logic [TAG_W-1:0] r_pre_tag;
    logic [P_W-1:0]   r_pre_a, r_pre_acc;
    logic [BP_W-1:0]  r_pre_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_vld <= 1'b0;
            r_pre_sgn <= 1'b0;
            r_pre_tag <= '0;
            r_pre_a   <= '0;
            r_pre_b   <= '0;
            r_pre_acc <= '0;
        end else if (w_en) begin
            r_pre_vld <= bus.in_valid;
            r_pre_sgn <= w_a_neg ^ w_b_neg;
            r_pre_tag <= bus.in_tag;
            r_pre_a   <= P_W'(w_a_mag);
            r_pre_b   <= BP_W'(w_b_mag);
            r_pre_acc <= '0;
        end
    end

    // Element 0 is the pre-stage, element i+1 the output of shift-add stage i.
    logic             w_vld [NS+1];
    logic             w_sgn [NS+1];
    logic [TAG_W-1:0] w_tag [NS+1];
    logic [P_W-1:0]   w_a   [NS+1];
    logic [BP_W-1:0]  w_b   [NS+1];
    logic [P_W-1:0]   w_acc [NS+1];

    assign w_vld[0] = r_pre_vld;
    assign w_sgn[0] = r_pre_sgn;
    assign w_tag[0] = r_pre_tag;
    assign w_a[0]   = r_pre_a;
    assign w_b[0]   = r_pre_b;
    assign w_acc[0] = r_pre_acc;

    for (genvar i = 0; i < NS; i++) begin : g_stage
        mult_pipe_rdx_stage #(
            .P_W   (P_W),
            .BP_W  (BP_W),
            .K     (K),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_en),
            .i_vld (w_vld[i]),
            .i_sgn (w_sgn[i]),
            .i_tag (w_tag[i]),
            .i_a   (w_a[i]),
            .i_b   (w_b[i]),
            .i_acc (w_acc[i]),
            .o_vld (w_vld[i+1]),
            .o_sgn (w_sgn[i+1]),
            .o_tag (w_tag[i+1]),
            .o_a   (w_a[i+1]),
            .o_b   (w_b[i+1]),
            .o_acc (w_acc[i+1])
        );
    end

    // Shifted operands leaving the last stage are spent.
    logic w_unused;
    assign w_unused = ^{w_a[NS], w_b[NS]};

    logic             r_out_vld;
    logic [P_W-1:0]   r_out_p;
    logic [TAG_W-1:0] r_out_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out_p   <= '0;
            r_out_tag <= '0;
        end else if (w_en) begin
            r_out_vld <= w_vld[NS];
            r_out_p   <= w_sgn[NS] ? -w_acc[NS] : w_acc[NS];
            r_out_tag <= w_tag[NS];
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.out_p     = r_out_p;
    assign bus.out_tag   = r_out_tag;
endmodule

// File: tb/tb_mult_pipe_rdx.sv
// Bench: four multiplier configurations share one stimulus stream
// (B_W/K = 8/2, 8/1, 8/4, 7/2). Each has its own in-order scoreboard fed by
// a plain-arithmetic product model; directed cases run on config 0.
module tb_mult_pipe_rdx;
    localparam int NC = 4;
    localparam int CFG_BW [NC] = '{8, 8, 8, 7};
    localparam int CFG_K  [NC] = '{2, 1, 4, 2};

    logic       clk, rst;
    logic       vld, sgn, ordy;
    logic [7:0] a, b;
    logic [3:0] tag;

    logic        ov [NC];
    logic        ir [NC];
    logic [15:0] op [NC];
    logic [3:0]  ot [NC];
    int          ndone [NC];
    int          nacc  [NC];

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    // Reference: integer product of the operands as interpreted in their mode.
    function automatic logic [15:0] ref_prod(input logic s, input logic [7:0] a8,
                                             input logic [7:0] b8, input int bw);
        longint av, bv, m;
        av = longint'(a8);
        if (s && a8[7]) av = av - 256;
        m  = (longint'(1) << bw) - 1;
        bv = longint'(b8) & m;
        if (s && bv[bw-1]) bv = bv - (longint'(1) << bw);
        return 16'((av * bv) & ((longint'(1) << (8 + bw)) - 1));
    endfunction

    for (genvar g = 0; g < NC; g++) begin : cfg
        localparam int BW = CFG_BW[g];
        localparam int KK = CFG_K[g];

        mult_pipe_rdx_if #(.A_W(8), .B_W(BW), .TAG_W(4)) bus ();

        mult_pipe_rdx #(.A_W(8), .B_W(BW), .K(KK), .TAG_W(4)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.in_valid  = vld;
        assign bus.in_signed = sgn;
        assign bus.in_a      = a;
        assign bus.in_b      = b[BW-1:0];
        assign bus.in_tag    = tag;
        assign bus.out_ready = ordy;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign op[g] = 16'(bus.out_p);
        assign ot[g] = bus.out_tag;

        logic [19:0] q[$];
        int n_done, n_acc;
        assign ndone[g] = n_done;
        assign nacc[g]  = n_acc;

        // Inputs change just after posedge, so the negedge view is what the
        // next posedge will transfer.
        always @(negedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                n_done <= 0;
                n_acc  <= 0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    chk($sformatf("cfg%0d_result_expected", g), 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        chk($sformatf("cfg%0d_tag_prod", g), {12'd0, ot[g], op[g]}, {12'd0, q[0]});
                        q.pop_front();
                    end
                    n_done <= n_done + 1;
                end
                if (vld && bus.in_ready) begin
                    q.push_back({tag, ref_prod(sgn, a, b, BW)});
                    n_acc <= n_acc + 1;
                end
            end
        end
    end

    // One isolated transfer into an empty pipe: latency of every config,
    // plus product and tag of config 0.
    task automatic one(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [3:0] it, input logic [15:0] ep);
        int first [NC];
        int n;
        bit all_seen;
        logic [15:0] p0;
        logic [3:0]  t0;
        for (int g = 0; g < NC; g++) first[g] = -1;
        p0 = '0; t0 = '0;
        ordy = 1'b1; sgn = s; a = ia; b = ib; tag = it; vld = 1'b1;
        n = 0; all_seen = 1'b0;
        while (!all_seen && n < 30) begin
            @(posedge clk); n++;
            #1 vld = 1'b0;
            @(negedge clk);
            all_seen = 1'b1;
            for (int g = 0; g < NC; g++) begin
                if (first[g] < 0 && ov[g]) begin
                    first[g] = n;
                    if (g == 0) begin p0 = op[0]; t0 = ot[0]; end
                end
                if (first[g] < 0) all_seen = 1'b0;
            end
        end
        for (int g = 0; g < NC; g++)
            chk($sformatf("lat_cfg%0d", g), 32'(first[g]),
                32'((CFG_BW[g] + CFG_K[g] - 1) / CFG_K[g] + 2));
        chk("prod", 32'(p0), 32'(ep));
        chk("tag", 32'(t0), 32'(it));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        vld = 1'b0; ordy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 8 back-to-back inputs, consumer holds off cycles 7..9.
    task automatic stall_test();
        int base, idx;
        base = ndone[0];
        idx = 0;
        a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom); tag = 4'd0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            ordy = !(cyc >= 7 && cyc <= 9);
            vld  = (idx < 8);
            @(negedge clk);
            if (cyc <= 12)
                chk($sformatf("stall_in_ready_c%0d", cyc), 32'(ir[0]),
                    32'(!(cyc >= 7 && cyc <= 9)));
            @(posedge clk); #1;
            if (vld && ir[0]) begin
                idx++;
                a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom); tag = 4'(idx);
            end
        end
        idle(20);
        chk("stall_accepted", 32'(idx), 32'd8);
        chk("stall_delivered", 32'(ndone[0] - base), 32'd8);
    endtask

    // Reset with the pipe full and a result held at the output.
    task automatic reset_test();
        ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vld = 1'b1; sgn = 1'($urandom); a = 8'($urandom); b = 8'($urandom); tag = 4'(i + 10);
            @(posedge clk); #1;
        end
        vld = 1'b0; ordy = 1'b0;
        chk("rst_pre_out_valid", 32'(ov[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_out_p", 32'(op[0]), 32'd0);
        chk("rst_out_tag", 32'(ot[0]), 32'd0);
        ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        one(1'b0, 8'd3, 8'd5, 4'd9, 16'd15);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; vld = 1'b0; sgn = 1'b0; a = '0; b = '0; tag = '0; ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(ov[0]), 32'd0);
        chk("reset_in_ready", 32'(ir[0]), 32'd1);
        chk("reset_out_p", 32'(op[0]), 32'd0);
        chk("reset_out_tag", 32'(ot[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        one(1'b0, 8'd255, 8'd255, 4'd5, 16'hFE01);
        one(1'b1, 8'h80,  8'h80,  4'd1, 16'h4000);
        one(1'b1, 8'h80,  8'h7F,  4'd2, 16'hC080);
        one(1'b1, 8'h00,  8'hFF,  4'd3, 16'h0000);
        one(1'b1, 8'hFF,  8'hFF,  4'd4, 16'h0001);

        stall_test();
        idle(5);
        reset_test();
        idle(5);

        for (int c = 0; c < 2400; c++) begin
            vld  = ($urandom_range(0, 99) < 75);
            sgn  = 1'($urandom);
            a    = pick();
            b    = pick();
            tag  = 4'($urandom);
            ordy = ($urandom_range(0, 99) < 80);
            @(posedge clk); #1;
        end
        idle(30);
        for (int g = 0; g < NC; g++) begin
            chk($sformatf("cfg%0d_all_delivered", g), 32'(ndone[g]), 32'(nacc[g]));
            chk($sformatf("cfg%0d_enough_pairs", g), 32'(nacc[g] >= 1000), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mult_pipe_rdx.md
MULT_PIPE_RDX -- requirements
Module: mult_pipe_rdx

Interface
REQ-001 SHALL have parameter A_W, default 8: multiplicand width in bits, minimum 2.
REQ-002 SHALL have parameter B_W, default 8: multiplier width in bits, minimum 2.
REQ-003 SHALL have parameter K, default 2: multiplier bits retired per stage, legal values 1, 2, 4.
REQ-004 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operand pair.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the offered pair this cycle.
REQ-009 SHALL have port in_signed, input, 1 bit: 1 = treat the operands as two's complement; 0 = treat them as unsigned.
REQ-010 SHALL have port in_a, input, A_W bits: multiplicand.
REQ-011 SHALL have port in_b, input, B_W bits: multiplier.
REQ-012 SHALL have port in_tag, input, TAG_W bits: user tag returned with the result.
REQ-013 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-015 SHALL have port out_p, output, A_W+B_W bits: the product.
REQ-016 SHALL have port out_tag, output, TAG_W bits: the tag of the result on out_p.

Function
REQ-017 SHALL define NS = ceil(B_W/K); the pipeline SHALL be one pre-stage, then NS shift-add stages, then one post-stage, for a latency of NS+2 cycles from acceptance to out_valid when there is no stall.
REQ-018 SHALL accept a transfer on in_valid && in_ready and SHALL complete a transfer on out_valid && out_ready.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready), a global stall: while stalled, every stage register, valid bit and tag SHALL hold its value.
REQ-020 Pre-stage SHALL register the magnitudes of in_a and in_b (absolute value when in_signed=1 and the MSB is set, raw value otherwise), the result sign (msb_a XOR msb_b) & in_signed, the tag, and a zeroed accumulator of A_W+B_W bits.
REQ-021 Shift-add stage i SHALL add (a_mag * b_mag[K-1:0]) to the accumulator, shift a_mag left by K and b_mag right by K; the partial product SHALL be formed from the K bits, not by K repeated single-bit adds in series.
REQ-022 When B_W is not a multiple of K, the stage logic SHALL treat the missing upper multiplier bits as zero.
REQ-023 Post-stage SHALL output the two's-complement negation of the accumulator when the sign is 1, and the accumulator unchanged otherwise.
REQ-024 Magnitude of the most-negative operand (-2^(A_W-1) or -2^(B_W-1)) SHALL be held as an unsigned value of A_W or B_W bits, so no overflow occurs; the product of two most-negative operands SHALL be exact.
REQ-025 SHALL sustain one transfer per cycle when out_ready is continuously 1, SHALL preserve order, and SHALL neither lose nor duplicate any transfer under any out_ready pattern.
REQ-026 A bubble (in_valid=0 on an accepted cycle) SHALL propagate as valid=0; data registers under valid=0 MAY hold any value but out_p SHALL NOT be sampled by the consumer.
REQ-027 Operands of mixed signed and unsigned mode in flight together SHALL each be computed in their own mode.

Reset
REQ-028 On rst=1, regardless of clk, all valid bits, out_valid, out_p, out_tag and all stage data registers SHALL clear to 0 immediately.
REQ-029 in_ready SHALL be 1 during and after reset, because out_valid is 0.
REQ-030 A reset asserted mid-operation SHALL discard every in-flight transaction; no stale result SHALL appear after reset is released.

Structure
REQ-031 Shared package mult_pipe_pkg SHALL hold the NS computation function and the legal-K check, which is an elaboration error for K not in {1,2,4}.
REQ-032 One sub-module, mult_pipe_rdx_stage (a single shift-add stage with stall enable), SHALL be instantiated NS times by a generate loop.

Verification
REQ-033 A_W=B_W=8, K=2, in_signed=0, a=255, b=255 -> out_p=0xFE01 exactly 6 cycles after acceptance, tag returned.
REQ-034 in_signed=1: (-128)*(-128) -> 0x4000; (-128)*127 -> 0xC080; 0*(-1) -> 0x0000.
REQ-035 8 back-to-back inputs with out_ready held 0 for cycles 7-9 -> in_ready=0 on exactly those cycles, all 8 results delivered in order, none lost.
REQ-036 rst pulsed with 4 transactions in flight -> out_valid=0 immediately; the next accepted input is the first result out.
REQ-037 Rerun with K=1 (latency 10), K=4 (latency 4), and B_W=7 with K=2 (NS=4) -> 1000 random mixed-mode pairs match a reference model.
